// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: per-bit 2-flop synchronizer followed by a tick-sampled
// debounce filter, with rise/fall strobes and a sticky change-pending flag.
module gpio_in_debounce #(
    parameter int                 WIDTH          = 32,
    parameter int                 TICK_DIV       = 50000,
    parameter int                 STABLE_SAMPLES = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE    = '0
) (
    input  logic             CLK0_PAD,
    input  logic             DEVRST_N,
    input  logic [WIDTH-1:0] GPIO_PAD,
    input  logic             CHG_CLR,
    output logic [WIDTH-1:0] GPIO_IN_DB,
    output logic [WIDTH-1:0] GPIO_RISE,
    output logic [WIDTH-1:0] GPIO_FALL,
    output logic             CHG_PEND
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int             CW         = $clog2(STABLE_SAMPLES + 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0] sync1_reg, sync2_reg;
    logic [WIDTH-1:0] db_reg, db_next;
    logic [WIDTH-1:0] rise_reg, rise_next;
    logic [WIDTH-1:0] fall_reg, fall_next;
    logic [PW-1:0]    presc_reg;
    logic             chg_reg;
    logic             tick;
    logic [CW-1:0]    cnt_reg  [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];

    assign tick = (presc_reg == PRESC_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic mismatch;
            logic accept;

            assign mismatch = sync2_reg[gi] ^ db_reg[gi];
            assign accept   = mismatch & tick & (cnt_reg[gi] == CNT_LAST);

            // Any cycle where the input agrees with the debounced level restarts the count.
            assign cnt_next[gi]  = (!mismatch || accept) ? '0 :
                                   (tick ? cnt_reg[gi] + CW'(1) : cnt_reg[gi]);
            assign db_next[gi]   = accept ? sync2_reg[gi] : db_reg[gi];
            assign rise_next[gi] = accept &  sync2_reg[gi];
            assign fall_next[gi] = accept & ~sync2_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK0_PAD or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            sync1_reg <= RESET_VALUE;
            sync2_reg <= RESET_VALUE;
            db_reg    <= RESET_VALUE;
            rise_reg  <= '0;
            fall_reg  <= '0;
            presc_reg <= '0;
            chg_reg   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            sync1_reg <= GPIO_PAD;
            sync2_reg <= sync1_reg;
            db_reg    <= db_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            // A new edge takes priority over a clear arriving in the same cycle.
            if (|(rise_reg | fall_reg)) begin
                chg_reg <= 1'b1;
            end else if (CHG_CLR) begin
                chg_reg <= 1'b0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign GPIO_IN_DB = db_reg;
    assign GPIO_RISE  = rise_reg;
    assign GPIO_FALL  = fall_reg;
    assign CHG_PEND   = chg_reg;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: directed scenarios plus random pad activity, checked
// by a queue scoreboard fed from a tick-counting reference model.
module tb_gpio_in_debounce;

    localparam int          W  = 32;
    localparam int          TD = 4;
    localparam int          SS = 3;
    localparam logic [31:0] RV = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pad = 32'h0;
    logic        chg_clr = 1'b0;
    logic [31:0] db_o, rise_o, fall_o;
    logic        chg_o;

    int total = 0;
    int bad = 0;
    int n_strobes = 0;

    always #5 clk = ~clk;

    gpio_in_debounce #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .RESET_VALUE(RV)
    ) dut (
        .CLK0_PAD(clk), .DEVRST_N(rst_n), .GPIO_PAD(pad), .CHG_CLR(chg_clr),
        .GPIO_IN_DB(db_o), .GPIO_RISE(rise_o), .GPIO_FALL(fall_o), .CHG_PEND(chg_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted on the edge where the SS-th prescaler tick
    // falls inside an unbroken run of disagreement between the delayed pad and db.
    typedef struct { logic [31:0] rise; logic [31:0] fall; logic [31:0] db; } ev_t;
    ev_t         exp_q[$];
    logic [31:0] pad_hist[$];
    int unsigned edge_n;
    int unsigned run_start[W];
    int unsigned ticks;
    logic [31:0] m_db, m_rise, m_fall, s2, strobe_prev;
    logic        m_chg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0;
            pad_hist.delete();
            pad_hist.push_back(RV);
            pad_hist.push_back(RV);
            for (int i = 0; i < W; i++) run_start[i] = 0;
            m_db = RV; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        end else begin
            edge_n++;
            s2 = pad_hist.pop_front();
            pad_hist.push_back(pad);
            strobe_prev = m_rise | m_fall;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (s2[i] == m_db[i]) begin
                    run_start[i] = 0;
                end else begin
                    if (run_start[i] == 0) run_start[i] = edge_n;
                    ticks = edge_n / TD - (run_start[i] - 1) / TD;
                    if ((edge_n % TD == 0) && ticks >= SS) begin
                        m_db[i] = s2[i];
                        if (s2[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                        run_start[i] = 0;
                    end
                end
            end
            if (strobe_prev != 0) m_chg = 1'b1;
            else if (chg_clr) m_chg = 1'b0;
            if ((m_rise | m_fall) != 0) exp_q.push_back('{m_rise, m_fall, m_db});
        end
    end

    // Monitor: samples on the falling edge, pops an expected event whenever either side shows one.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst_n) begin
            chk("rst_db", db_o, RV);
            chk("rst_rise", rise_o, 32'h0);
            chk("rst_fall", fall_o, 32'h0);
            chk("rst_chg", {31'b0, chg_o}, 32'h0);
        end else begin
            if ((rise_o | fall_o) != 0 || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", rise_o | fall_o, 32'h0);
                end else begin
                    ev = exp_q.pop_front();
                    n_strobes++;
                    $display("strobe @%0t rise=%h fall=%h db=%h", $time, rise_o, fall_o, db_o);
                    chk("rise", rise_o, ev.rise);
                    chk("fall", fall_o, ev.fall);
                    chk("db_at_strobe", db_o, ev.db);
                end
            end
            chk("db", db_o, m_db);
            chk("chg", {31'b0, chg_o}, {31'b0, m_chg});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int found;
        // Reset with all pads high, then release and let them debounce.
        pad = 32'hFFFF_FFFF;
        cyc(3);
        rst_n = 1'b1;
        cyc(9);
        chk("t1_db_still_low", db_o, 32'h0);
        cyc(5);
        chk("t1_db_high", db_o, 32'hFFFF_FFFF);
        pad = 32'h0;
        cyc(20);
        chk("t1_db_low", db_o, 32'h0);

        // Clean rise on bit 0.
        pad = 32'h1;
        cyc(20);
        chk("t2_db", db_o, 32'h1);

        // Glitch and bounce on bit 5.
        pad[5] = 1'b1; cyc(6); pad[5] = 1'b0; cyc(20);
        for (int k = 0; k < 3; k++) begin
            pad[5] = 1'b1; cyc(5); pad[5] = 1'b0; cyc(1);
        end
        cyc(20);
        chk("t3_db5", {31'b0, db_o[5]}, 32'h0);

        // Bits 3 and 31 fall together.
        pad = 32'h8000_0009;
        cyc(20);
        pad = 32'h1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (fall_o != 0) found = 1; else cyc(1);
        end
        chk("t4_fall_seen", found, 1);
        if (found == 1) begin
            chk("t4_fall", fall_o, 32'h8000_0008);
            chk("t4_db", db_o, 32'h1);
        end
        cyc(5);

        // Clear racing a new strobe, then a lone clear.
        chg_clr = 1'b1; cyc(1); chg_clr = 1'b0; cyc(1);
        chk("t5_chg_cleared", {31'b0, chg_o}, 32'h0);
        pad = 32'h0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if ((m_rise | m_fall) != 0) found = 1; else cyc(1);
        end
        chk("t5_strobe_seen", found, 1);
        chg_clr = 1'b1; cyc(1); chg_clr = 1'b0;
        chk("t5_set_wins", {31'b0, chg_o}, 32'h1);
        chg_clr = 1'b1; cyc(1); chg_clr = 1'b0;
        chk("t5_clr", {31'b0, chg_o}, 32'h0);
        cyc(10);

        // Reset mid-count on bit 7, then full restart.
        pad = 32'h80;
        cyc(9);
        rst_n = 1'b0;
        cyc(2);
        chk("t6_db_in_reset", db_o, 32'h0);
        rst_n = 1'b1;
        cyc(9);
        chk("t6_db_restart", db_o, 32'h0);
        cyc(10);
        chk("t6_db", db_o, 32'h80);

        // Random pad activity with occasional clears and one mid-run reset.
        for (int it = 0; it < 2500; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15) pad = pad ^ (32'h1 << $urandom_range(0, 31));
            else if (r < 17) pad = $urandom;
            chg_clr = ($urandom_range(0, 7) == 0);
            if (it % 200 == 199) begin
                chg_clr = 1'b0;
                cyc(20);
            end
            if (it == 1200) begin
                rst_n = 1'b0; cyc(2); rst_n = 1'b1;
            end
            cyc(1);
        end
        chg_clr = 1'b0;
        cyc(20);

        chk("queue_empty", exp_q.size(), 32'h0);
        chk("strobes_seen", {31'b0, n_strobes > 10}, 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
